pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
Consumes the stall controls produced by hazard detection (pcwrite, IF_ID_write, muxcntrl) and the branch redirect from the MEM stage, and applies them. Owns the PC register, the IF/ID pipeline register and the control half of the ID/EX register in the pipelined LEGv8 CPU. Inserts bubbles, holds stages and flushes wrong-path instructions. Drives a kill strobe to the EX/MEM register.

Parameters:
ADDR_W, 64, PC / branch target width
INSTR_W, 32, instruction width
CTRL_W, 10, width of the decoded control bundle carried into ID/EX
FLUSH_DEPTH, 3, stage in which branches resolve (3 = MEM); sets the flush window length
NOP_INSTR, 32'hD503201F, encoding written into IF/ID on flush

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
pcwrite  in  1  from hazard detection; 0 = hold PC
IF_ID_write  in  1  from hazard detection; 0 = hold IF/ID
muxcntrl  in  1  from hazard detection; 0 = insert bubble into ID/EX
br_taken  in  1  MEM-stage branch/CBZ/B.LT resolved taken
br_target  in  ADDR_W  redirect address
imem_instr  in  INSTR_W  instruction at current pc (combinational imem)
id_ctrl  in  CTRL_W  control bundle decoded in ID
pc  out  ADDR_W  fetch address
if_id_pc  out  ADDR_W  PC of instruction in ID
if_id_instr  out  INSTR_W  instruction in ID
if_id_valid  out  1  ID holds a real instruction
id_ex_ctrl  out  CTRL_W  control bundle into EX
id_ex_valid  out  1  EX holds a real instruction
flushing  out  1  kill strobe to EX/MEM; high while in FLUSH

Behaviour:
- Reset (reset=0, async): pc=0, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, id_ex_ctrl=0, id_ex_valid=0, flushing=0, state=RUN, flush_cnt=0. Deassertion is taken on the next rising edge.
- All outputs are registered. Nothing is combinational from the inputs.
- State RUN, no branch:
  - PC: if pcwrite=1, pc <= pc+4, modulo 2^ADDR_W (wrap from all-ones-minus-3 to 0). Else pc holds.
  - IF/ID: if IF_ID_write=1, load {pc, imem_instr} and set if_id_valid=1. Else hold all three fields.
  - ID/EX: if muxcntrl=1, id_ex_ctrl <= id_ctrl and id_ex_valid <= if_id_valid. Else bubble: id_ex_ctrl=0, id_ex_valid=0.
  - The three controls are applied independently, even when their combination is inconsistent.
- RUN with br_taken=1: the redirect has priority over every stall input in the same cycle.
  - pc <= br_target.
  - IF/ID <= {0, NOP_INSTR}, if_id_valid=0.
  - ID/EX <= bubble.
  - flushing <= 1.
  - flush_cnt <= FLUSH_DEPTH-2. Go to FLUSH.
- FLUSH state:
  - flushing=1.
  - Stall inputs are ignored: pcwrite, IF_ID_write and muxcntrl are treated as 1, because they were computed from squashed instructions.
  - br_taken is ignored (wrong path).
  - PC advances normally and IF/ID loads normally; ID/EX loads from IF/ID normally.
  - Each cycle, if flush_cnt==0, go to RUN with flushing <= 0. Else decrement flush_cnt.
  - FLUSH_DEPTH=2: flush_cnt loads 0, so flushing stays high for exactly 1 cycle.
  - FLUSH_DEPTH=3: flushing is high for 2 cycles.
- Hold on stall: no field of a held register changes, including valid bits.
- Reset asserted mid-flush: returns to RUN immediately with all reset values. No residual flushing.
- Back-to-back branch on the first RUN cycle after a flush is accepted normally.

Optional Feature:
STALL_PERF_EN
- Defined: adds outputs stall_cycles (32) and flush_cycles (32), both reset to 0.
  - stall_cycles increments every RUN cycle with br_taken=0 and muxcntrl=0.
  - flush_cycles increments every cycle with flushing=1.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Test Plan:
1. Reset released, all controls=1, imem_instr=32'h8B020020 held → pc=0,4,8,12 on successive edges. if_id_pc=0 and if_id_valid=1 after edge 1. id_ex_valid=1 after edge 2.
2. Load-use stall: one cycle of pcwrite=IF_ID_write=muxcntrl=0 with pc=8 → pc stays 8, IF/ID unchanged, id_ex_ctrl=0 and id_ex_valid=0 for that cycle. Next cycle resumes with pc=12.
3. br_taken=1, br_target=64'h100, with pcwrite=0 in the same cycle → pc=0x100, if_id_instr=NOP_INSTR, if_id_valid=0, id_ex_valid=0, flushing=1 for 2 cycles (FLUSH_DEPTH=3). A stall input asserted during FLUSH is ignored: pc goes to 0x104, then 0x108.
4. br_taken=1 during FLUSH with target 0x200 → ignored; pc continues sequentially from 0x100.
5. pc=64'hFFFFFFFFFFFFFFFC, pcwrite=1 → pc=0 next edge.
6. reset driven low asynchronously mid-flush (between edges) → all outputs at reset values immediately, flushing=0. With STALL_PERF_EN, counters read 0.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: applies the hazard-detection stall controls and the
// MEM-stage branch redirect to the PC, the IF/ID register and the control
// half of the ID/EX register. A taken branch squashes the wrong-path
// instructions and holds the kill strobe (flushing) for FLUSH_DEPTH-1 cycles.
//
// Ports:
//   clk, reset          rising-edge clock, async active-low reset
//   pcwrite             0 = hold PC
//   IF_ID_write         0 = hold IF/ID
//   muxcntrl            0 = bubble into ID/EX
//   br_taken, br_target MEM-stage redirect
//   imem_instr          instruction at pc (combinational imem)
//   id_ctrl             control bundle decoded in ID
//   pc                  fetch address
//   if_id_pc/instr/valid   IF/ID contents
//   id_ex_ctrl/valid    ID/EX control contents
//   flushing            kill strobe to EX/MEM
// Optional feature macro STALL_PERF_EN adds stall_cycles / flush_cycles
// saturating performance counters.
module pipeline_stall_ctrl #(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned INSTR_W     = 32,
  parameter int unsigned CTRL_W      = 10,
  parameter int unsigned FLUSH_DEPTH = 3,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pcwrite,
  input  logic               IF_ID_write,
  input  logic               muxcntrl,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic [CTRL_W-1:0]  id_ctrl,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid,
  output logic [CTRL_W-1:0]  id_ex_ctrl,
  output logic               id_ex_valid,
  output logic               flushing
`ifdef STALL_PERF_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_cycles
`endif
);

  localparam int unsigned CNT_W = (FLUSH_DEPTH > 2) ? $clog2(FLUSH_DEPTH) : 1;

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]         state, state_d;
  logic [CNT_W-1:0]   flush_cnt, flush_cnt_d;
  logic [ADDR_W-1:0]  pc_d, if_id_pc_d;
  logic [INSTR_W-1:0] if_id_instr_d;
  logic               if_id_valid_d;
  logic [CTRL_W-1:0]  id_ex_ctrl_d;
  logic               id_ex_valid_d;
  logic               flushing_d;
  logic               pc_en, if_id_en, id_ex_en;

  // State and all output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      flush_cnt   <= '0;
      pc          <= '0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      id_ex_ctrl  <= '0;
      id_ex_valid <= 1'b0;
      flushing    <= 1'b0;
    end else begin
      state       <= state_d;
      flush_cnt   <= flush_cnt_d;
      pc          <= pc_d;
      if_id_pc    <= if_id_pc_d;
      if_id_instr <= if_id_instr_d;
      if_id_valid <= if_id_valid_d;
      id_ex_ctrl  <= id_ex_ctrl_d;
      id_ex_valid <= id_ex_valid_d;
      flushing    <= flushing_d;
    end
  end

  // Next-state and next register values
  always_comb begin
    state_d       = state;
    flush_cnt_d   = flush_cnt;
    pc_d          = pc;
    if_id_pc_d    = if_id_pc;
    if_id_instr_d = if_id_instr;
    if_id_valid_d = if_id_valid;
    id_ex_ctrl_d  = id_ex_ctrl;
    id_ex_valid_d = id_ex_valid;
    flushing_d    = flushing;
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_ex_en      = 1'b0;

    case (state)
      RUN: begin
        if (br_taken) begin
          // Redirect outranks every stall input in the same cycle
          pc_d          = br_target;
          if_id_pc_d    = '0;
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
          id_ex_ctrl_d  = '0;
          id_ex_valid_d = 1'b0;
          flushing_d    = 1'b1;
          flush_cnt_d   = CNT_W'(FLUSH_DEPTH - 2);
          state_d       = FLUSH;
        end else begin
          pc_en    = pcwrite;
          if_id_en = IF_ID_write;
          id_ex_en = 1'b1;
        end
      end
      FLUSH: begin
        // Stall controls came from squashed instructions: force all to 1
        pc_en    = 1'b1;
        if_id_en = 1'b1;
        id_ex_en = 1'b1;
        if (flush_cnt == '0) begin
          state_d    = RUN;
          flushing_d = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt - CNT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase

    if (pc_en) pc_d = pc + ADDR_W'(4);
    if (if_id_en) begin
      if_id_pc_d    = pc;
      if_id_instr_d = imem_instr;
      if_id_valid_d = 1'b1;
    end
    if (id_ex_en) begin
      // In RUN muxcntrl selects load vs bubble; in FLUSH it is forced high
      if (muxcntrl || (state == FLUSH)) begin
        id_ex_ctrl_d  = id_ctrl;
        id_ex_valid_d = if_id_valid;
      end else begin
        id_ex_ctrl_d  = '0;
        id_ex_valid_d = 1'b0;
      end
    end
  end

`ifdef STALL_PERF_EN
  // Saturating stall / flush cycle counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if ((state == RUN) && !br_taken && !muxcntrl && (stall_cycles != 32'hFFFFFFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (flushing && (flush_cycles != 32'hFFFFFFFF))
        flush_cycles <= flush_cycles + 32'd1;
    end
  end
`else
  // Performance counters not built
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

  localparam logic [31:0] NOP  = 32'hD503201F;
  localparam logic [31:0] INS  = 32'h8B020020;
  localparam logic [9:0]  CTRL = 10'h2A5;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcwrite, IF_ID_write, muxcntrl, br_taken;
  logic [63:0] br_target;
  logic [31:0] imem_instr;
  logic [9:0]  id_ctrl;
  logic [63:0] pc, if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [9:0]  id_ex_ctrl;
  logic        id_ex_valid;
  logic        flushing;
`ifdef STALL_PERF_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  pipeline_stall_ctrl dut (
    .clk(clk), .reset(reset), .pcwrite(pcwrite), .IF_ID_write(IF_ID_write),
    .muxcntrl(muxcntrl), .br_taken(br_taken), .br_target(br_target),
    .imem_instr(imem_instr), .id_ctrl(id_ctrl), .pc(pc), .if_id_pc(if_id_pc),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid), .id_ex_ctrl(id_ex_ctrl),
    .id_ex_valid(id_ex_valid), .flushing(flushing)
`ifdef STALL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one rising edge, then settle before sampling/driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic pw, input logic iw, input logic mx);
    pcwrite = pw; IF_ID_write = iw; muxcntrl = mx;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".pc"},       pc, 64'h0);
    chk({tag, ".ifpc"},     if_id_pc, 64'h0);
    chk({tag, ".ifinstr"},  64'(if_id_instr), 64'(NOP));
    chk({tag, ".ifvalid"},  64'(if_id_valid), 64'h0);
    chk({tag, ".exctrl"},   64'(id_ex_ctrl), 64'h0);
    chk({tag, ".exvalid"},  64'(id_ex_valid), 64'h0);
    chk({tag, ".flushing"}, 64'(flushing), 64'h0);
`ifdef STALL_PERF_EN
    chk({tag, ".stallcnt"}, 64'(stall_cycles), 64'h0);
    chk({tag, ".flushcnt"}, 64'(flush_cycles), 64'h0);
`endif
  endtask

  initial begin
    reset = 1'b0;
    ctl(1'b1, 1'b1, 1'b1);
    br_taken = 1'b0; br_target = '0;
    imem_instr = INS; id_ctrl = CTRL;
    #12;
    chk_reset("rst");
    reset = 1'b1;

    // Straight-line fetch
    step();
    chk("t1e1.pc", pc, 64'd4);
    chk("t1e1.ifpc", if_id_pc, 64'd0);
    chk("t1e1.ifinstr", 64'(if_id_instr), 64'(INS));
    chk("t1e1.ifvalid", 64'(if_id_valid), 64'd1);
    chk("t1e1.exvalid", 64'(id_ex_valid), 64'd0);
    step();
    chk("t1e2.pc", pc, 64'd8);
    chk("t1e2.ifpc", if_id_pc, 64'd4);
    chk("t1e2.exvalid", 64'(id_ex_valid), 64'd1);
    chk("t1e2.exctrl", 64'(id_ex_ctrl), 64'(CTRL));

    // Load-use stall at pc=8
    ctl(1'b0, 1'b0, 1'b0);
    step();
    chk("t2.pc", pc, 64'd8);
    chk("t2.ifpc", if_id_pc, 64'd4);
    chk("t2.ifvalid", 64'(if_id_valid), 64'd1);
    chk("t2.exctrl", 64'(id_ex_ctrl), 64'd0);
    chk("t2.exvalid", 64'(id_ex_valid), 64'd0);
    ctl(1'b1, 1'b1, 1'b1);
    step();
    chk("t2r.pc", pc, 64'd12);
    chk("t2r.ifpc", if_id_pc, 64'd8);
    chk("t2r.exvalid", 64'(id_ex_valid), 64'd1);

    // Taken branch with a stall in the same cycle
    br_taken = 1'b1; br_target = 64'h100; ctl(1'b0, 1'b1, 1'b1);
    step();
    chk("t3.pc", pc, 64'h100);
    chk("t3.ifinstr", 64'(if_id_instr), 64'(NOP));
    chk("t3.ifpc", if_id_pc, 64'h0);
    chk("t3.ifvalid", 64'(if_id_valid), 64'd0);
    chk("t3.exvalid", 64'(id_ex_valid), 64'd0);
    chk("t3.exctrl", 64'(id_ex_ctrl), 64'd0);
    chk("t3.flushing", 64'(flushing), 64'd1);
    // Stall inputs during FLUSH are ignored
    br_taken = 1'b0; ctl(1'b0, 1'b0, 1'b0);
    step();
    chk("t3f1.pc", pc, 64'h104);
    chk("t3f1.ifpc", if_id_pc, 64'h100);
    chk("t3f1.ifvalid", 64'(if_id_valid), 64'd1);
    chk("t3f1.exctrl", 64'(id_ex_ctrl), 64'(CTRL));
    chk("t3f1.exvalid", 64'(id_ex_valid), 64'd0);
    chk("t3f1.flushing", 64'(flushing), 64'd1);
    // Wrong-path branch during FLUSH is ignored
    br_taken = 1'b1; br_target = 64'h200; ctl(1'b0, 1'b1, 1'b1);
    step();
    chk("t4.pc", pc, 64'h108);
    chk("t4.ifpc", if_id_pc, 64'h104);
    chk("t4.exvalid", 64'(id_ex_valid), 64'd1);
    chk("t4.flushing", 64'(flushing), 64'd0);
`ifdef STALL_PERF_EN
    chk("perf.stall", 64'(stall_cycles), 64'd1);
    chk("perf.flush", 64'(flush_cycles), 64'd2);
`endif

    // Back-to-back branch on first RUN cycle after flush
    br_taken = 1'b1; br_target = 64'h300; ctl(1'b1, 1'b1, 1'b1);
    step();
    chk("bb.pc", pc, 64'h300);
    chk("bb.flushing", 64'(flushing), 64'd1);
    br_taken = 1'b0;
    step();
    chk("bbf1.pc", pc, 64'h304);
    chk("bbf1.flushing", 64'(flushing), 64'd1);
    step();
    chk("bbf2.pc", pc, 64'h308);
    chk("bbf2.flushing", 64'(flushing), 64'd0);

    // PC wrap-around
    br_taken = 1'b1; br_target = 64'hFFFF_FFFF_FFFF_FFF8;
    step();
    br_taken = 1'b0;
    step();
    chk("t5.pcfc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    chk("t5.wrap", pc, 64'h0);
    chk("t5.ifpc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Async reset mid-flush
    br_taken = 1'b1; br_target = 64'h400;
    step();
    br_taken = 1'b0;
    chk("t6.preflush", 64'(flushing), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset("t6");
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("t6r.pc", pc, 64'd4);
    chk("t6r.flushing", 64'(flushing), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
